// File: rtl/ofdm_frame_ctrl.sv
// ofdm_frame_ctrl: per-frame sequencer for ofdm_sync. Snoops the framer's output
// handshake, collects the decoded SIGNAL length (or substitutes a safe length on a bad
// header / timeout), issues it to the framer and keeps frame statistics.
module ofdm_frame_ctrl #(
  parameter int unsigned MAX_NUM_SYMBOLS = 512,
  parameter int unsigned HDR_TIMEOUT     = 4096,
  parameter int unsigned ABORT_SYMBOLS   = 1,
  localparam int unsigned NW             = $clog2(MAX_NUM_SYMBOLS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          mon_tvalid,
  input  logic          mon_tready,
  input  logic          mon_tlast,
  input  logic          mon_sof,
  input  logic          mon_eof,
  input  logic [NW-1:0] hdr_tdata,
  input  logic          hdr_err,
  input  logic          hdr_tvalid,
  output logic          hdr_tready,
  output logic [NW-1:0] num_symbols,
  output logic          num_symbols_valid,
  output logic          busy,
  output logic [NW-1:0] sym_cnt,
  output logic [31:0]   frame_cnt,
  output logic [15:0]   abort_cnt,
  output logic [15:0]   timeout_cnt,
  output logic [15:0]   err_cnt
);

  localparam int unsigned TW = (HDR_TIMEOUT > 2) ? $clog2(HDR_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_HDR = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NW-1:0]   num_symbols_q, num_symbols_d;
  logic            nsv_q, nsv_d;
  logic            busy_q, busy_d;
  logic            hdr_tready_q, hdr_tready_d;
  logic [NW-1:0]   sym_cnt_q, sym_cnt_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     abort_cnt_q, abort_cnt_d;
  logic [15:0]     timeout_cnt_q, timeout_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic beat, sof_beat, eof_beat, tlast_beat;
  logic hdr_hs, hdr_bad;

  // Qualify the snooped framer flags with an actual transfer
  assign beat       = mon_tvalid & mon_tready;
  assign sof_beat   = beat & mon_sof;
  assign eof_beat   = beat & mon_eof;
  assign tlast_beat = beat & mon_tlast;

  // Header handshake and legality of the decoded length
  assign hdr_hs  = hdr_tvalid & hdr_tready_q;
  assign hdr_bad = hdr_err | (hdr_tdata == '0) | (hdr_tdata > NW'(MAX_NUM_SYMBOLS));

  // Register bank: state, timer, issued length and statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      num_symbols_q <= '0;
      nsv_q         <= 1'b0;
      busy_q        <= 1'b0;
      hdr_tready_q  <= 1'b0;
      sym_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      abort_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      num_symbols_q <= num_symbols_d;
      nsv_q         <= nsv_d;
      busy_q        <= busy_d;
      hdr_tready_q  <= hdr_tready_d;
      sym_cnt_q     <= sym_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      abort_cnt_q   <= abort_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Next-state, length issue and saturating statistics
  always_comb begin
    logic restart;
    state_d       = state_q;
    timer_d       = timer_q;
    num_symbols_d = num_symbols_q;
    nsv_d         = 1'b0;
    sym_cnt_d     = sym_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    abort_cnt_d   = abort_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    err_cnt_d     = err_cnt_q;
    restart       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sof_beat) restart = 1'b1;
      end
      ST_WAIT_HDR: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        // A header arriving in the expiry cycle takes precedence over the timeout
        if (hdr_hs) begin
          nsv_d   = 1'b1;
          state_d = ST_RUN;
          if (hdr_bad) begin
            num_symbols_d = NW'(ABORT_SYMBOLS);
            if (abort_cnt_q != '1) abort_cnt_d = abort_cnt_q + 16'd1;
          end else begin
            num_symbols_d = hdr_tdata;
          end
        end else if (timer_q == '0) begin
          nsv_d         = 1'b1;
          state_d       = ST_RUN;
          num_symbols_d = NW'(ABORT_SYMBOLS);
          if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
        // Unexpected SOF restarts header collection; a length issued this cycle still goes out
        if (sof_beat) begin
          restart = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (tlast_beat && (sym_cnt_q != '1)) sym_cnt_d = sym_cnt_q + NW'(1);
        if (eof_beat) begin
          state_d = ST_IDLE;
          if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 32'd1;
          if (sof_beat) restart = 1'b1;
        end else if (sof_beat) begin
          restart = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d   = ST_WAIT_HDR;
      timer_d   = TW'(HDR_TIMEOUT - 1);
      sym_cnt_d = '0;
    end

    // Clear overrides everything except the last issued length
    if (clear) begin
      state_d       = ST_IDLE;
      timer_d       = '0;
      nsv_d         = 1'b0;
      sym_cnt_d     = '0;
      frame_cnt_d   = '0;
      abort_cnt_d   = '0;
      timeout_cnt_d = '0;
      err_cnt_d     = '0;
    end

    hdr_tready_d = (state_d == ST_WAIT_HDR);
    busy_d       = (state_d != ST_IDLE);
  end

  assign hdr_tready        = hdr_tready_q;
  assign num_symbols       = num_symbols_q;
  assign num_symbols_valid = nsv_q;
  assign busy              = busy_q;
  assign sym_cnt           = sym_cnt_q;
  assign frame_cnt         = frame_cnt_q;
  assign abort_cnt         = abort_cnt_q;
  assign timeout_cnt       = timeout_cnt_q;
  assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_ofdm_frame_ctrl.sv
// Testbench for ofdm_frame_ctrl: directed scenarios with literal expectations plus a
// randomized stream, all outputs compared every cycle against a behavioural model.
module tb_ofdm_frame_ctrl;

  localparam int unsigned MAXS  = 512;
  localparam int unsigned TO    = 4096;
  localparam int unsigned ABORT = 1;
  localparam int unsigned NW    = $clog2(MAXS + 1);
  localparam int          SYMSAT = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic          mon_sof = 1'b0, mon_eof = 1'b0;
  logic [NW-1:0] hdr_tdata = '0;
  logic          hdr_err = 1'b0, hdr_tvalid = 1'b0;
  logic          hdr_tready, num_symbols_valid, busy;
  logic [NW-1:0] num_symbols, sym_cnt;
  logic [31:0]   frame_cnt;
  logic [15:0]   abort_cnt, timeout_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  ofdm_frame_ctrl #(.MAX_NUM_SYMBOLS(MAXS), .HDR_TIMEOUT(TO), .ABORT_SYMBOLS(ABORT)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .mon_sof(mon_sof), .mon_eof(mon_eof),
    .hdr_tdata(hdr_tdata), .hdr_err(hdr_err), .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
    .num_symbols(num_symbols), .num_symbols_valid(num_symbols_valid), .busy(busy),
    .sym_cnt(sym_cnt), .frame_cnt(frame_cnt), .abort_cnt(abort_cnt),
    .timeout_cnt(timeout_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 no frame, 1 collecting header, 2 frame in progress
  int     m_mode = 0;
  longint m_edge = 0;
  longint m_deadline = 0;
  int     m_num = 0;
  bit     m_pulse = 0;
  int     m_sym = 0;
  longint m_frame = 0;
  int     m_abort = 0, m_timeout = 0, m_err = 0;

  function automatic int sat16(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_begin_hdr();
    m_mode     = 1;
    m_deadline = m_edge + TO;   // length forced on the TO-th edge after the SOF edge
    m_sym      = 0;
  endtask

  task automatic model_update();
    bit b, sof, eof, tl;
    int cur;
    if (reset) begin
      m_mode = 0; m_num = 0; m_pulse = 0; m_sym = 0;
      m_frame = 0; m_abort = 0; m_timeout = 0; m_err = 0;
      return;
    end
    m_edge++;
    b   = mon_tvalid && mon_tready;
    sof = b && mon_sof;
    eof = b && mon_eof;
    tl  = b && mon_tlast;
    m_pulse = 0;
    if (clear) begin
      m_mode = 0; m_sym = 0; m_frame = 0; m_abort = 0; m_timeout = 0; m_err = 0;
      return;
    end
    cur = m_mode;
    if (cur == 0) begin
      if (sof) model_begin_hdr();
    end else if (cur == 1) begin
      if (hdr_tvalid) begin
        m_pulse = 1;
        m_mode  = 2;
        if (hdr_err || hdr_tdata == 0 || int'(hdr_tdata) > MAXS) begin
          m_num = ABORT; m_abort = sat16(m_abort);
        end else begin
          m_num = int'(hdr_tdata);
        end
      end else if (m_edge == m_deadline) begin
        m_pulse = 1; m_mode = 2; m_num = ABORT; m_timeout = sat16(m_timeout);
      end
      if (sof) begin
        m_err = sat16(m_err);
        model_begin_hdr();
      end
    end else begin
      if (tl && m_sym < SYMSAT) m_sym++;
      if (eof) begin
        if (m_frame < 64'hFFFF_FFFF) m_frame++;
        m_mode = 0;
        if (sof) model_begin_hdr();
      end else if (sof) begin
        m_err = sat16(m_err);
        model_begin_hdr();
      end
    end
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk or posedge reset) begin
    model_update();
    #1;
    check("num_symbols_valid", num_symbols_valid, m_pulse);
    check("num_symbols", num_symbols, m_num);
    check("busy", busy, m_mode != 0);
    check("hdr_tready", hdr_tready, m_mode == 1);
    check("sym_cnt", sym_cnt, m_sym);
    check("frame_cnt", frame_cnt, m_frame);
    check("abort_cnt", abort_cnt, m_abort);
    check("timeout_cnt", timeout_cnt, m_timeout);
    check("err_cnt", err_cnt, m_err);
  end

  // ---------------- stimulus helpers (start and end on a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input bit sof, input bit eof, input bit tl);
    mon_tvalid = 1; mon_tready = 1; mon_sof = sof; mon_eof = eof; mon_tlast = tl;
    @(negedge clk);
    mon_tvalid = 0; mon_tready = 0; mon_sof = 0; mon_eof = 0; mon_tlast = 0;
  endtask

  task automatic hdr(input int val, input bit err);
    hdr_tvalid = 1; hdr_tdata = NW'(val); hdr_err = err;
    @(negedge clk);
    hdr_tvalid = 0; hdr_err = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  int bad_vals[4] = '{600, 20, 0, 513};
  bit bad_errs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    idle(3);
    reset = 0;
    idle(1);
    check("reset busy", busy, 0);
    check("reset num_symbols", num_symbols, 0);
    check("reset frame_cnt", frame_cnt, 0);

    // Unqualified SOF (no beat) is ignored
    mon_tvalid = 1; mon_sof = 1; idle(1); mon_tvalid = 0; mon_sof = 0;
    check("sof without beat", busy, 0);

    // Nominal frame: header 100 edges after SOF edge
    beat(1, 0, 0);
    idle(99);
    check("no early pulse", num_symbols_valid, 0);
    hdr(20, 0);
    check("t1 pulse", num_symbols_valid, 1);
    check("t1 num", num_symbols, 20);
    repeat (20) beat(0, 0, 1);
    check("t1 sym_cnt", sym_cnt, 20);
    beat(0, 1, 0);
    check("t1 frame_cnt", frame_cnt, 1);
    check("t1 busy", busy, 0);

    // Bad headers: too long, parity error, zero, MAX+1
    for (int i = 0; i < 4; i++) begin
      do_clear();
      beat(1, 0, 0);
      idle(2);
      hdr(bad_vals[i], bad_errs[i]);
      check("t2 pulse", num_symbols_valid, 1);
      check("t2 num", num_symbols, ABORT);
      check("t2 abort_cnt", abort_cnt, 1);
      beat(0, 1, 0);
    end

    // MAX length is legal; sym_cnt saturates
    do_clear();
    beat(1, 0, 0);
    hdr(512, 0);
    check("max num", num_symbols, 512);
    check("max abort_cnt", abort_cnt, 0);
    repeat (SYMSAT + 7) beat(0, 0, 1);
    check("sym_cnt sat", sym_cnt, SYMSAT);
    beat(0, 1, 1);

    // Timeout: forced length on the 4096th edge after the SOF edge
    do_clear();
    beat(1, 0, 0);
    idle(TO - 1);
    check("t3 no pulse yet", num_symbols_valid, 0);
    idle(1);
    check("t3 pulse", num_symbols_valid, 1);
    check("t3 num", num_symbols, ABORT);
    check("t3 timeout_cnt", timeout_cnt, 1);
    hdr_tvalid = 1; hdr_tdata = NW'(9);
    check("t3 late hdr_tready", hdr_tready, 0);
    idle(1);
    hdr_tvalid = 0;
    check("t3 late hdr no pulse", num_symbols_valid, 0);
    beat(0, 1, 0);

    // Header in the expiry cycle wins
    do_clear();
    beat(1, 0, 0);
    idle(TO - 1);
    hdr(33, 0);
    check("t4 pulse", num_symbols_valid, 1);
    check("t4 num", num_symbols, 33);
    check("t4 timeout_cnt", timeout_cnt, 0);
    beat(0, 1, 0);

    // Second SOF during a frame
    do_clear();
    beat(1, 0, 0);
    hdr(20, 0);
    repeat (3) beat(0, 0, 1);
    beat(1, 0, 0);
    check("t5 err_cnt", err_cnt, 1);
    check("t5 hdr_tready", hdr_tready, 1);
    check("t5 sym_cnt", sym_cnt, 0);
    hdr(8, 0);
    check("t5 pulse", num_symbols_valid, 1);
    check("t5 num", num_symbols, 8);
    beat(0, 1, 0);

    // Asynchronous reset while waiting for a header
    beat(1, 0, 0);
    idle(3);
    #2 reset = 1;
    #1;
    check("t6 hdr_tready", hdr_tready, 0);
    check("t6 busy", busy, 0);
    check("t6 pulse", num_symbols_valid, 0);
    idle(2);
    reset = 0;
    idle(20);
    check("t6 no pulse after release", num_symbols_valid, 0);
    check("t6 busy after release", busy, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 20000; i++) begin
      mon_tvalid = ($urandom_range(0, 9) < 7);
      mon_tready = ($urandom_range(0, 9) < 7);
      mon_tlast  = ($urandom_range(0, 4) == 0);
      mon_sof    = ($urandom_range(0, 99) == 0);
      mon_eof    = ($urandom_range(0, 59) == 0);
      hdr_tvalid = ($urandom_range(0, 19) == 0);
      hdr_err    = ($urandom_range(0, 4) == 0);
      hdr_tdata  = ($urandom_range(0, 3) == 0) ? NW'($urandom_range(0, SYMSAT))
                                                : NW'($urandom_range(1, MAXS));
      clear      = ($urandom_range(0, 1999) == 0);
      @(negedge clk);
    end
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; mon_sof = 0; mon_eof = 0;
    hdr_tvalid = 0; hdr_err = 0; clear = 0;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
